seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Parametrised multi-cycle restoring divider for the multi-cycle CPU's DIV/DIVU execution path.
- Supports signed and unsigned modes selected per operation.
- Uses a start/busy/done handshake and produces one quotient bit per clock.
- Results are registered and held stable until the next accepted start, so the control FSM can stall on busy and then write HI/LO.

Parameters:
- WIDTH, 32, operand/result width in bits (≥4).
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset, synchronous, active-high
- start  input  1  request; sampled only in IDLE
- sign_mode  input  1  1 = signed (DIV), 0 = unsigned (DIVU); latched at start
- dividend  input  WIDTH  numerator; latched at start
- divisor  input  WIDTH  denominator; latched at start
- busy  output  1  high while an operation is in flight
- done  output  1  one-cycle pulse when results update
- quotient  output  WIDTH  registered quotient (LO)
- remainder  output  WIDTH  registered remainder (HI)
- div_by_zero  output  1  registered; set with done when divisor==0, held with results

Behaviour:
- Reset (synchronous): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0. Reset in any state aborts the operation with no done pulse.
- States: IDLE, CALC, FIX.
  - IDLE, start=1 → latch sign_mode; latch |dividend| and |divisor| (abs only when sign_mode=1); latch q_neg = sign_mode & (dividend[MSB]^divisor[MSB]) and r_neg = sign_mode & dividend[MSB]; set counter=WIDTH, busy=1; go to CALC.
  - CALC: one restoring step per cycle on a 2*WIDTH partial register. Shift left 1; if upper half ≥ |divisor|, subtract and set LSB=1. Decrement counter; when counter reaches 1, go to FIX.
  - FIX: apply sign correction. Quotient is negated if q_neg. Remainder is negated if r_neg. Write quotient, remainder, and div_by_zero; pulse done=1; busy=0; go to IDLE.
- Latency: start sampled at edge k → done high in the cycle after edge k+WIDTH+1 (WIDTH+2 cycles). This is constant for all operands unless the optional feature is enabled.
- done is high for exactly one cycle. Outputs hold until the FIX of the next operation.
- start while busy=1 is ignored and not queued. start in the same cycle done is high is accepted (state is IDLE), giving back-to-back operation.
- Operand inputs are don't-care after the start cycle.
- Arithmetic: quotient truncates toward zero; remainder takes the sign of the dividend (MIPS semantics). Abs/negate is two's complement within WIDTH bits.
- Signed overflow, MIN/−1: quotient=MIN (0x80000000 at WIDTH=32), remainder=0, div_by_zero=0.
- Divide by zero (any mode): quotient=all ones, remainder=original dividend (unmodified), div_by_zero=1. These values are forced in FIX; latency is unchanged.
- No X is ever driven on outputs.

Optional Feature:
- Macro: SEQ_DIV_EARLY_OUT_EN.
- Defined: in IDLE on start, if divisor==0 or |dividend| < |divisor| (unsigned compare of the latched magnitudes), skip CALC and go directly to FIX with magnitude quotient=0 and remainder=|dividend| (the divide-by-zero override still applies). Latency for these cases is 2 cycles. All other results are bit-identical.
- Undefined: latency is always WIDTH+2.

Decomposition:
- Package seq_div_pkg holds:
  - state enum (IDLE, CALC, FIX) with 2-bit encoding;
  - localparam helpers for CNT_W;
  - constants for divide-by-zero quotient fill and signed MIN pattern, generated per WIDTH via functions.
- One sub-module, seq_div_neg: parametrised conditional two's-complement negate (in, en → out), instantiated for operand abs and result sign fix.

Test Plan:
- Unsigned 100/7, sign_mode=0 → quotient=14, remainder=2, div_by_zero=0; done exactly 34 cycles after the start edge; busy high for 33 cycles.
- Signed −7/2 (0xFFFFFFF9/0x2), sign_mode=1 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; same operands with sign_mode=0 → quotient=0x7FFFFFFC, remainder=1.
- Signed 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0.
- Divide by zero 5/0, both modes → quotient=0xFFFFFFFF, remainder=5, div_by_zero=1. With SEQ_DIV_EARLY_OUT_EN, done 2 cycles after start.
- start pulsed at cycles 5 and 10 of an operation → second start ignored, single done. start asserted in the done cycle → second result follows WIDTH+2 cycles later.
- reset asserted mid-CALC (cycle 12) → next edge all outputs 0, no done. A new start afterwards completes with the correct result.

Source files
------------

// File: rtl/seq_div_pkg.sv
// Shared types and width helpers for the seq_div restoring divider.
package seq_div_pkg;

    localparam int unsigned MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    // All-ones quotient reported for divide by zero, low w bits valid.
    function automatic logic [MAX_W-1:0] dbz_fill(input int unsigned w);
        return (MAX_W'(1) << w) - MAX_W'(1);
    endfunction

    // Most negative two's-complement value, low w bits valid.
    function automatic logic [MAX_W-1:0] min_pattern(input int unsigned w);
        return MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/seq_div_neg.sv
// Conditional two's-complement negate: out = en ? -in : in, within WIDTH bits.
module seq_div_neg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] in,
    input  logic             en,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        if (en) begin
            out = ~in + WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_div.sv
// Multi-cycle restoring divider (signed/unsigned) with start/busy/done handshake.
// Optional SEQ_DIV_EARLY_OUT_EN: skip iteration when divisor==0 or |dividend|<|divisor|.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned      CNT_W = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] DBZ_Q = WIDTH'(dbz_fill(WIDTH));

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [2*WIDTH-1:0]   part_q;
    logic [2*WIDTH-1:0]   part_d;
    logic [WIDTH-1:0]     dvsr_q;
    logic                 q_neg_q;
    logic                 r_neg_q;
    logic                 dbz_q;
    logic                 busy_q;
    logic                 done_q;
    logic [WIDTH-1:0]     quo_q;
    logic [WIDTH-1:0]     rem_q;
    logic                 dbz_out_q;

    logic [WIDTH-1:0]     abs_dvd;
    logic [WIDTH-1:0]     abs_dvs;
    logic [WIDTH-1:0]     q_fix;
    logic [WIDTH-1:0]     r_fix;
    logic [WIDTH:0]       trial;
    logic [WIDTH:0]       diff;

    seq_div_neg #(.WIDTH(WIDTH)) u_abs_dvd (
        .in  (dividend),
        .en  (sign_mode & dividend[WIDTH-1]),
        .out (abs_dvd)
    );

    seq_div_neg #(.WIDTH(WIDTH)) u_abs_dvs (
        .in  (divisor),
        .en  (sign_mode & divisor[WIDTH-1]),
        .out (abs_dvs)
    );

    seq_div_neg #(.WIDTH(WIDTH)) u_fix_q (
        .in  (part_q[WIDTH-1:0]),
        .en  (q_neg_q),
        .out (q_fix)
    );

    seq_div_neg #(.WIDTH(WIDTH)) u_fix_r (
        .in  (part_q[2*WIDTH-1:WIDTH]),
        .en  (r_neg_q),
        .out (r_fix)
    );

    // Trial remainder keeps the bit shifted out of the upper half, so it is WIDTH+1 wide.
    always_comb begin
        trial  = part_q[2*WIDTH-1:WIDTH-1];
        diff   = trial - {1'b0, dvsr_q};
        part_d = {part_q[2*WIDTH-2:0], 1'b0};
        if (trial >= {1'b0, dvsr_q}) begin
            part_d = {diff[WIDTH-1:0], part_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            part_q    <= '0;
            dvsr_q    <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            dbz_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        part_q  <= {{WIDTH{1'b0}}, abs_dvd};
                        dvsr_q  <= abs_dvs;
                        q_neg_q <= sign_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg_q <= sign_mode & dividend[WIDTH-1];
                        dbz_q   <= (divisor == '0);
                        cnt_q   <= CNT_W'(WIDTH);
                        busy_q  <= 1'b1;
                        state_q <= CALC;
`ifdef SEQ_DIV_EARLY_OUT_EN
                        if ((divisor == '0) || (abs_dvd < abs_dvs)) begin
                            part_q  <= {abs_dvd, {WIDTH{1'b0}}};
                            cnt_q   <= '0;
                            state_q <= FIX;
                        end
`endif
                    end
                end
                CALC: begin
                    part_q <= part_d;
                    cnt_q  <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    // With a zero divisor the upper half ends as |dividend|, so the
                    // sign-corrected remainder is exactly the original dividend.
                    quo_q     <= dbz_q ? DBZ_Q : q_fix;
                    rem_q     <= r_fix;
                    dbz_out_q <= dbz_q;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div at WIDTH=32.
module tb_seq_div;

    localparam int W   = 32;
    localparam int LAT = W + 1;  // posedges from the start-sampling edge to done visible

    logic         clk;
    logic         reset;
    logic         start;
    logic         sign_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    seq_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sign_mode   (sign_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one operation and wait (bounded) for done; lat=-1 on timeout.
    task automatic do_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int bcnt);
        @(negedge clk);
        sign_mode = sm;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        lat  = -1;
        bcnt = busy ? 1 : 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        sign_mode = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, div_by_zero} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero});
        end
        n_checks++;
        if ({quotient, remainder} !== {2*W{1'b0}}) begin
            n_fail++;
            $display("FAIL reset_data: got q=%h r=%h expected 0/0", quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat, bcnt;
        do_op(1'b0, 32'd100, 32'd7, lat, bcnt);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++;
            $display("FAIL udiv_latency: got %0d expected %0d", lat, LAT);
        end
        n_checks++;
        if (bcnt !== W + 1) begin
            n_fail++;
            $display("FAIL udiv_busy_cycles: got %0d expected %0d", bcnt, W + 1);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {32'd14, 32'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL udiv_100_7: got q=%h r=%h z=%b expected q=e r=2 z=0",
                     quotient, remainder, div_by_zero);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: got %b expected 0", done);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({quotient, remainder} !== {32'd14, 32'd2}) begin
            n_fail++;
            $display("FAIL result_hold: got q=%h r=%h expected e/2", quotient, remainder);
        end
    endtask

    task automatic test_signed();
        int lat, bcnt;
        do_op(1'b1, 32'hFFFF_FFF9, 32'h2, lat, bcnt);
        n_checks++;
        if ({quotient, remainder} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL sdiv_m7_2: got q=%h r=%h expected fffffffd/ffffffff", quotient, remainder);
        end
        do_op(1'b0, 32'hFFFF_FFF9, 32'h2, lat, bcnt);
        n_checks++;
        if ({quotient, remainder} !== {32'h7FFF_FFFC, 32'h1}) begin
            n_fail++;
            $display("FAIL udiv_fff9_2: got q=%h r=%h expected 7ffffffc/1", quotient, remainder);
        end
        do_op(1'b1, 32'd7, 32'hFFFF_FFFE, lat, bcnt);
        n_checks++;
        if ({quotient, remainder} !== {32'hFFFF_FFFD, 32'h1}) begin
            n_fail++;
            $display("FAIL sdiv_7_m2: got q=%h r=%h expected fffffffd/1", quotient, remainder);
        end
    endtask

    task automatic test_boundaries();
        int lat, bcnt;
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {32'h8000_0000, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL sdiv_overflow: got q=%h r=%h z=%b expected 80000000/0/0",
                     quotient, remainder, div_by_zero);
        end
        do_op(1'b0, 32'hFFFF_FFFF, 32'h1, lat, bcnt);
        n_checks++;
        if ({quotient, remainder} !== {32'hFFFF_FFFF, 32'h0}) begin
            n_fail++;
            $display("FAIL udiv_max_1: got q=%h r=%h expected ffffffff/0", quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        int lat, bcnt, exp_lat;
`ifdef SEQ_DIV_EARLY_OUT_EN
        exp_lat = 1;
`else
        exp_lat = LAT;
`endif
        for (int m = 0; m < 2; m++) begin
            do_op(m[0], 32'd5, 32'd0, lat, bcnt);
            n_checks++;
            if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, 32'd5, 1'b1}) begin
                n_fail++;
                $display("FAIL div_zero_mode%0d: got q=%h r=%h z=%b expected ffffffff/5/1",
                         m, quotient, remainder, div_by_zero);
            end
            n_checks++;
            if (lat !== exp_lat) begin
                n_fail++;
                $display("FAIL div_zero_latency_mode%0d: got %0d expected %0d", m, lat, exp_lat);
            end
        end
        do_op(1'b1, 32'hFFFF_FFF9, 32'd0, lat, bcnt);
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1}) begin
            n_fail++;
            $display("FAIL div_zero_neg: got q=%h r=%h z=%b expected ffffffff/fffffff9/1",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_start_ignored();
        int ndone, first;
        @(negedge clk);
        sign_mode = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 32'd9;
        divisor  = 32'd3;
        ndone = 0;
        first = -1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            start = (n == 5 || n == 10);
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                if (first < 0) first = n;
            end
        end
        start = 1'b0;
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL busy_start_done_count: got %0d expected 1", ndone);
        end
        n_checks++;
        if (first !== LAT) begin
            n_fail++;
            $display("FAIL busy_start_latency: got %0d expected %0d", first, LAT);
        end
        n_checks++;
        if ({quotient, remainder} !== {32'd14, 32'd2}) begin
            n_fail++;
            $display("FAIL busy_start_result: got q=%h r=%h expected e/2", quotient, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt, lat2;
        do_op(1'b0, 32'd5, 32'd0, lat, bcnt);
        // Still inside the done cycle: the next edge must accept this start.
        sign_mode = 1'b1;
        dividend  = 32'hFFFF_FFF9;
        divisor   = 32'h2;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat2 = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat2 = n;
                break;
            end
        end
        n_checks++;
        if (lat2 !== LAT) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d expected %0d", lat2, LAT);
        end
        n_checks++;
        if ({quotient, remainder, div_by_zero} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_result: got q=%h r=%h z=%b expected fffffffd/ffffffff/0",
                     quotient, remainder, div_by_zero);
        end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt, ndone;
        @(negedge clk);
        sign_mode = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, div_by_zero, quotient, remainder} !== {3'b000, {2*W{1'b0}}}) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got b=%b d=%b z=%b q=%h r=%h expected all 0",
                     busy, done, div_by_zero, quotient, remainder);
        end
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_done: got %0d expected 0", ndone);
        end
        do_op(1'b0, 32'd1000, 32'd10, lat, bcnt);
        n_checks++;
        if ({quotient, remainder, lat} !== {32'd100, 32'd0, LAT}) begin
            n_fail++;
            $display("FAIL post_reset_op: got q=%h r=%h lat=%0d expected 64/0/%0d",
                     quotient, remainder, lat, LAT);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_boundaries();
        test_div_zero();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
